// File: rtl/memory_stage.sv
// MEM pipeline stage: issues data-memory accesses, resolves branches/jumps on
// completion, and registers the MEM/WB latch. States: IDLE, WAIT, HALTED.
module memory_stage (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ex_valid,
    input  logic [31:0] ex_aluout,
    input  logic        ex_zero,
    input  logic [31:0] ex_wdat,
    input  logic        ex_dren,
    input  logic        ex_dwen,
    input  logic [4:0]  ex_wsel,
    input  logic        ex_regwr,
    input  logic        ex_wsig,
    input  logic        ex_halt,
    input  logic        ex_beq,
    input  logic        ex_bne,
    input  logic        ex_jsig,
    input  logic        ex_jrsig,
    input  logic [31:0] ex_brval,
    input  logic [31:0] ex_laddr,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    input  logic [31:0] dmemload,
    input  logic        dhit,
    output logic        mem_stall,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        flush,
    output logic [31:0] wb_wdat,
    output logic [4:0]  wb_wsel,
    output logic        wb_wen,
    output logic        wb_halt
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic [1:0]  state;
    logic [31:0] addr_p1;
    logic [31:0] store_p1;
    logic        ren_p1;
    logic        wen_p1;

    logic mem_req;
    logic issue;
    logic in_wait;
    logic pending;
    logic complete;
    logic taken;

    always_comb begin
        // A halt never issues a memory access, even if its enables are set.
        mem_req  = ex_valid & (ex_dren | ex_dwen) & ~ex_halt;
        issue    = nRST & (state == ST_IDLE) & mem_req;
        in_wait  = nRST & (state == ST_WAIT);
        pending  = issue | in_wait;
        complete = nRST & (((state == ST_IDLE) & ex_valid & ~mem_req) | (pending & dhit));
        taken    = ex_jrsig | ex_jsig | (ex_beq & ex_zero) | (ex_bne & ~ex_zero);

        dmemREN   = 1'b0;
        dmemWEN   = 1'b0;
        dmemaddr  = '0;
        dmemstore = '0;
        if (issue) begin
            dmemREN   = ex_dren & ~ex_dwen;
            dmemWEN   = ex_dwen;
            dmemaddr  = ex_aluout;
            dmemstore = ex_wdat;
        end else if (in_wait) begin
            dmemREN   = ren_p1;
            dmemWEN   = wen_p1;
            dmemaddr  = addr_p1;
            dmemstore = store_p1;
        end

        mem_stall   = pending & ~dhit;
        pc_redirect = complete & taken;
        flush       = complete & taken;
        pc_target   = '0;
        if (nRST) begin
            pc_target = ex_jrsig ? ex_laddr : ex_brval;
        end
    end

    // Request captured at issue so WAIT presents a stable access.
    always_ff @(posedge CLK) begin
        if (issue) begin
            addr_p1  <= ex_aluout;
            store_p1 <= ex_wdat;
            ren_p1   <= ex_dren & ~ex_dwen;
            wen_p1   <= ex_dwen;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= ST_IDLE;
            wb_wdat <= '0;
            wb_wsel <= '0;
            wb_wen  <= 1'b0;
            wb_halt <= 1'b0;
        end else begin
            wb_wen <= complete & ex_regwr;
            if (complete) begin
                wb_wdat <= ex_wsig ? dmemload : ex_aluout;
                wb_wsel <= ex_wsel;
            end
            case (state)
                ST_IDLE: begin
                    if (complete && ex_halt) begin
                        state   <= ST_HALTED;
                        wb_halt <= 1'b1;
                    end else if (issue && !dhit) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (dhit) begin
                        state <= ST_IDLE;
                    end
                end
                ST_HALTED: begin
                    state   <= ST_HALTED;
                    wb_halt <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
